// File: rtl/thr_tile_sequencer_if.sv
// ---------------------------------------------------------------------------
// thr_tile_sequencer_if
// Start/done handshake bundle between the tile sequencer and the engines it
// controls: the DMA reader, the PE array, the packer and the writeback engine.
//
// Signals
//   dma_start  / dma_done    DMA read of one tile
//   pe_start   / pe_done     per-PE start level and completion, NUM_PE wide
//   pack_start / pack_done   packer
//   wb_start   / wb_done     writeback engine
//
// Modports
//   master  sequencer side: drives the *_start levels and samples the *_done inputs
//   slave   engine side: the reverse direction
// ---------------------------------------------------------------------------
interface thr_tile_sequencer_if #(
   parameter int NUM_PE = 4
);
   logic              dma_start;
   logic              dma_done;
   logic [NUM_PE-1:0] pe_start;
   logic [NUM_PE-1:0] pe_done;
   logic              pack_start;
   logic              pack_done;
   logic              wb_start;
   logic              wb_done;

   modport master (
      output dma_start, pe_start, pack_start, wb_start,
      input  dma_done, pe_done, pack_done, wb_done
   );

   modport slave (
      input  dma_start, pe_start, pack_start, wb_start,
      output dma_done, pe_done, pack_done, wb_done
   );
endinterface

// File: rtl/thr_tile_sequencer.sv
// ---------------------------------------------------------------------------
// thr_tile_sequencer
// Top-level sequencer for the thresholding datapath. The sequencer runs the
// stages DMA_READ -> PROCESS -> PACK -> WRITEBACK once for each tile. The host
// sets the number of tiles at run time. The sequencer drives NUM_PE processing
// elements and uses a per-PE participation mask. A run can be aborted.
//
// Optional feature macro: THR_SEQ_WDOG_EN
//   defined   : each stage has a watchdog. When the stage runs for
//               timeout_cycles cycles without its done input, the sequencer
//               goes to the ERROR state and sets error and err_stage.
//   undefined : the design has no watchdog counter. error and err_stage are
//               always 0.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   start            1-cycle run request, accepted only in IDLE
//   tile_count       number of tiles, sampled when start is accepted
//   pe_mask          PE participation mask, sampled when start is accepted
//   abort            level input; returns the sequencer to IDLE from any state other than IDLE
//   timeout_cycles   watchdog limit per stage, 0 disables the watchdog
//   eng              engine handshake bundle (master modport); its NUM_PE
//                    must equal this module's NUM_PE
//   tile_idx         0-based index of the tile in flight
//   busy             1 in every state except IDLE
//   processing_done  1-cycle pulse when a run completes
//   error            sticky watchdog error
//   err_stage        stage that timed out: 0 DMA, 1 PE, 2 PACK, 3 WB
// All outputs are registered.
// ---------------------------------------------------------------------------
module thr_tile_sequencer #(
   parameter int NUM_PE    = 4,
   parameter int TILE_W    = 16,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [TILE_W-1:0]    tile_count,
   input  logic [NUM_PE-1:0]    pe_mask,
   input  logic                 abort,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   thr_tile_sequencer_if.master eng,
   output logic [TILE_W-1:0]    tile_idx,
   output logic                 busy,
   output logic                 processing_done,
   output logic                 error,
   output logic [1:0]           err_stage
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DMA_READ  = 3'd1,
      ST_PROCESS   = 3'd2,
      ST_PACK      = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERROR     = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [TILE_W-1:0]   count_q, count_d;
   logic [NUM_PE-1:0]   mask_q, mask_d;
   logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
   logic [NUM_PE-1:0]   sticky_q, sticky_d;

   logic                dma_start_q, dma_start_d;
   logic [NUM_PE-1:0]   pe_start_q, pe_start_d;
   logic                pack_start_q, pack_start_d;
   logic                wb_start_q, wb_start_d;
   logic                busy_q, busy_d;
   logic                done_pulse_q, done_pulse_d;

   // in_stage is 1 in the four stage states. stage_done is the completion
   // condition of the current stage.
   logic                in_stage;
   logic                stage_done;
   logic                pe_all_done;

`ifdef THR_SEQ_WDOG_EN
   logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic                 error_q, error_d;
   logic [1:0]           err_stage_q, err_stage_d;
   logic [1:0]           stage_code;
   logic                 wd_expired;
`endif

   // A PE counts as finished when it has finished earlier in this PROCESS
   // visit, when it finishes in this cycle, or when it does not participate.
   // With an all-zero mask the PROCESS state lasts one cycle.
   assign pe_all_done = &(sticky_q | eng.pe_done | ~mask_q);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      mask_d       = mask_q;
      tile_idx_d   = tile_idx_q;
      sticky_d     = sticky_q;
      done_pulse_d = 1'b0;
      in_stage     = 1'b0;
      stage_done   = 1'b0;
`ifdef THR_SEQ_WDOG_EN
      error_d      = error_q;
      err_stage_d  = err_stage_q;
      stage_code   = 2'd0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               count_d    = tile_count;
               mask_d     = pe_mask;
               tile_idx_d = '0;
`ifdef THR_SEQ_WDOG_EN
               error_d     = 1'b0;
               err_stage_d = 2'd0;
`endif
               state_d    = (tile_count == '0) ? ST_DONE : ST_DMA_READ;
            end
         end
         ST_DMA_READ: begin
            in_stage   = 1'b1;
            stage_done = eng.dma_done;
            if (eng.dma_done) begin
               sticky_d = '0;
               state_d  = ST_PROCESS;
            end
         end
         ST_PROCESS: begin
            in_stage   = 1'b1;
            stage_done = pe_all_done;
`ifdef THR_SEQ_WDOG_EN
            stage_code = 2'd1;
`endif
            // The sequencer records pe_done only for PEs that participate.
            sticky_d = sticky_q | (eng.pe_done & mask_q);
            if (pe_all_done) begin
               state_d = ST_PACK;
            end
         end
         ST_PACK: begin
            in_stage   = 1'b1;
            stage_done = eng.pack_done;
`ifdef THR_SEQ_WDOG_EN
            stage_code = 2'd2;
`endif
            if (eng.pack_done) begin
               state_d = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: begin
            in_stage   = 1'b1;
            stage_done = eng.wb_done;
`ifdef THR_SEQ_WDOG_EN
            stage_code = 2'd3;
`endif
            if (eng.wb_done) begin
               if (tile_idx_q == count_q - TILE_W'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  tile_idx_d = tile_idx_q + TILE_W'(1);
                  state_d    = ST_DMA_READ;
               end
            end
         end
         ST_DONE: begin
            done_pulse_d = 1'b1;
            state_d      = ST_IDLE;
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef THR_SEQ_WDOG_EN
      // If done and timeout occur in the same cycle, done wins.
      wd_expired = in_stage && !stage_done && (timeout_cycles != '0) &&
                   (wd_cnt_q == timeout_cycles - TIMEOUT_W'(1));
      if (wd_expired) begin
         state_d     = ST_ERROR;
         tile_idx_d  = tile_idx_q;
         error_d     = 1'b1;
         err_stage_d = stage_code;
      end
`endif

      // abort has priority over every done input and over the watchdog.
      // Bookkeeping stays as it was, so an abort during WRITEBACK does not
      // advance tile_idx. The sticky error flag is kept.
      if (abort && (state_q != ST_IDLE)) begin
         state_d      = ST_IDLE;
         tile_idx_d   = tile_idx_q;
         done_pulse_d = 1'b0;
`ifdef THR_SEQ_WDOG_EN
         error_d      = error_q;
         err_stage_d  = err_stage_q;
`endif
      end

`ifdef THR_SEQ_WDOG_EN
      // The counter restarts on every state entry. In cycle n of a stage,
      // wd_cnt_q holds n-1. The stage therefore expires at the end of its
      // timeout_cycles-th cycle.
      if ((state_d != state_q) || !in_stage) begin
         wd_cnt_d = '0;
      end else begin
         wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
      end
`endif

      // The outputs are decoded from the next state. Each start level
      // therefore changes on the same edge as the state.
      dma_start_d  = (state_d == ST_DMA_READ);
      pe_start_d   = (state_d == ST_PROCESS) ? mask_d : '0;
      pack_start_d = (state_d == ST_PACK);
      wb_start_d   = (state_d == ST_WRITEBACK);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         mask_q       <= '0;
         tile_idx_q   <= '0;
         sticky_q     <= '0;
         dma_start_q  <= 1'b0;
         pe_start_q   <= '0;
         pack_start_q <= 1'b0;
         wb_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         mask_q       <= mask_d;
         tile_idx_q   <= tile_idx_d;
         sticky_q     <= sticky_d;
         dma_start_q  <= dma_start_d;
         pe_start_q   <= pe_start_d;
         pack_start_q <= pack_start_d;
         wb_start_q   <= wb_start_d;
         busy_q       <= busy_d;
         done_pulse_q <= done_pulse_d;
      end
   end

`ifdef THR_SEQ_WDOG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_q    <= '0;
         error_q     <= 1'b0;
         err_stage_q <= 2'd0;
      end else begin
         wd_cnt_q    <= wd_cnt_d;
         error_q     <= error_d;
         err_stage_q <= err_stage_d;
      end
   end

   assign error     = error_q;
   assign err_stage = err_stage_q;
`else
   // Without the watchdog, the ERROR state cannot be reached and the
   // timeout inputs have no effect.
   logic unused_wdog;
   assign unused_wdog = ^{timeout_cycles, in_stage, stage_done};
   assign error       = 1'b0;
   assign err_stage   = 2'd0;
`endif

   assign eng.dma_start  = dma_start_q;
   assign eng.pe_start   = pe_start_q;
   assign eng.pack_start = pack_start_q;
   assign eng.wb_start   = wb_start_q;
   assign tile_idx        = tile_idx_q;
   assign busy            = busy_q;
   assign processing_done = done_pulse_q;

endmodule
